// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, row sampling, press/release
// debounce and key-face decode for the DE2 keypad.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] hexcode,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0] DB_TGT = 8'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    cand_col_q, cand_col_d;
    logic [3:0]    cand_row_q, cand_row_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    kcol_q, kcol_d;
    logic [3:0]    krow_q, krow_d;
    logic [3:0]    hex_q, hex_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic       tick;
    logic       row_one_low;
    logic       row_all_high;
    logic [7:0] cnt_inc;
    logic       cnt_done;
    logic [3:0] col_rot;

    function automatic logic one_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default:                            one_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        case (v)
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    endfunction

    // Index is {row, col}; matches the printed key faces.
    function automatic logic [3:0] face(input logic [1:0] r,
                                       input logic [1:0] c);
        case ({r, c})
            4'h0: face = 4'h1;
            4'h1: face = 4'h2;
            4'h2: face = 4'h3;
            4'h3: face = 4'hF;
            4'h4: face = 4'h4;
            4'h5: face = 4'h5;
            4'h6: face = 4'h6;
            4'h7: face = 4'hE;
            4'h8: face = 4'h7;
            4'h9: face = 4'h8;
            4'hA: face = 4'h9;
            4'hB: face = 4'hD;
            4'hC: face = 4'hA;
            4'hD: face = 4'h0;
            4'hE: face = 4'hB;
            default: face = 4'hC;
        endcase
    endfunction

    assign tick         = (div_q == DIV_LAST);
    assign row_one_low  = one_low(row_in);
    assign row_all_high = &row_in;
    assign cnt_inc      = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    assign cnt_done     = (cnt_inc >= DB_TGT);
    assign col_rot      = {col_q[2:0], col_q[3]};

    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + DW'(1);
        col_d      = col_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        cnt_d      = cnt_q;
        kcol_d     = kcol_q;
        krow_d     = krow_q;
        hex_d      = hex_q;
        valid_d    = 1'b0;
        held_d     = held_q;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (row_one_low) begin
                        cand_col_d = col_q;
                        cand_row_d = row_in;
                        cnt_d      = 8'd1;
                        state_d    = DEBOUNCE;
                    end else begin
                        col_d = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (row_in == cand_row_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            kcol_d  = cand_col_q;
                            krow_d  = cand_row_q;
                            hex_d   = face(low_idx(cand_row_q),
                                           low_idx(cand_col_q));
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = PRESSED;
                        end
                    end else begin
                        cnt_d   = 8'd0;
                        col_d   = col_rot;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    if (row_all_high) begin
                        cnt_d   = 8'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_all_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            cnt_d   = 8'd0;
                            held_d  = 1'b0;
                            col_d   = col_rot;
                            state_d = SCAN;
                        end
                    end else begin
                        // A bounce back to low is the same press, not a new one.
                        cnt_d   = 8'd0;
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            div_q      <= '0;
            col_q      <= 4'b1110;
            cand_col_q <= 4'hF;
            cand_row_q <= 4'hF;
            cnt_q      <= 8'd0;
            kcol_q     <= 4'hF;
            krow_q     <= 4'hF;
            hex_q      <= 4'h0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            col_q      <= col_d;
            cand_col_q <= cand_col_d;
            cand_row_q <= cand_row_d;
            cnt_q      <= cnt_d;
            kcol_q     <= kcol_d;
            krow_q     <= krow_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

    assign col_out   = col_q;
    assign key_col   = kcol_q;
    assign key_row   = krow_q;
    assign hexcode   = hex_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
